mlp_layer_sequencer: RTL

- Frame-level scheduler for a chain of NUM_LAYERS fc_layer instances, such as the five-layer MLP top.
- Drives each layer's i_start / i_func_start.
- Tracks per-layer input-buffer occupancy so consecutive frames pipeline across layers without overwriting a buffer still in use.
- Sits beside the MLP top: consumes the layers' o_busy and produces their start strobes plus frame-level handshakes.

---
 rtl/mlp_layer_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mlp_layer_sequencer.sv
// Frame scheduler for a chain of fc layers: issues start / func-start strobes per layer
// and tracks per-layer input-buffer occupancy so frames pipeline without overwrites.
module mlp_layer_sequencer #(
    parameter int NUM_LAYERS = 5,
    parameter int CIM_LAT    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_valid,
    output logic                  o_frame_ready,
    input  logic [NUM_LAYERS-1:0] i_layer_busy,
    output logic [NUM_LAYERS-1:0] o_start,
    output logic [NUM_LAYERS-1:0] o_func_start,
    output logic [NUM_LAYERS-1:0] o_next_busy,
    input  logic                  i_out_ready,
    output logic                  o_result_valid,
    output logic [CNT_W-1:0]      o_frames_done,
    output logic                  o_idle
);

    localparam int               LAT_W    = (CIM_LAT > 1) ? $clog2(CIM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(CIM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MVM,
        S_WAIT_OUT,
        S_FUNC
    } state_t;

    state_t           state_q [NUM_LAYERS];
    state_t           state_d [NUM_LAYERS];
    logic [LAT_W-1:0] cnt_q   [NUM_LAYERS];
    logic [LAT_W-1:0] cnt_d   [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] seen_q, seen_d;
    logic [NUM_LAYERS-1:0] full_q, full_d;
    logic [NUM_LAYERS-1:0] free;
    logic [NUM_LAYERS-1:0] func_done;
    logic [NUM_LAYERS-1:0] start_d, func_d;
    logic                  result_d, idle_d, any_active;
    logic [CNT_W-1:0]      frames_d;

    // A downstream buffer is free only when empty and its layer is not mid-load.
    always_comb begin
        for (int unsigned k = 0; k < NUM_LAYERS - 1; k++) begin
            free[k] = !full_q[k+1] && (state_q[k+1] != S_LOAD);
        end
        free[NUM_LAYERS-1] = i_out_ready;
    end

    assign o_next_busy   = ~free;
    assign o_frame_ready = !full_q[0] && (state_q[0] != S_LOAD);

    always_comb begin
        full_d     = full_q;
        seen_d     = seen_q;
        start_d    = '0;
        func_d     = '0;
        func_done  = '0;
        any_active = 1'b0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (state_q[k] != S_IDLE) begin
                any_active = 1'b1;
            end
            case (state_q[k])
                S_IDLE: begin
                    if (full_q[k] && !i_layer_busy[k]) begin
                        start_d[k] = 1'b1;
                        full_d[k]  = 1'b0;
                        seen_d[k]  = 1'b0;
                        state_d[k] = S_LOAD;
                    end
                end
                S_LOAD, S_FUNC: begin
                    // Completion is the falling edge of busy after it has been seen high.
                    if (seen_q[k] && !i_layer_busy[k]) begin
                        if (state_q[k] == S_LOAD) begin
                            cnt_d[k]   = LAT_LOAD;
                            state_d[k] = S_MVM;
                        end else begin
                            func_done[k] = 1'b1;
                            state_d[k]   = S_IDLE;
                        end
                    end else if (i_layer_busy[k]) begin
                        seen_d[k] = 1'b1;
                    end
                end
                S_MVM: begin
                    if (cnt_q[k] == '0) begin
                        state_d[k] = S_WAIT_OUT;
                    end else begin
                        cnt_d[k] = cnt_q[k] - 1'b1;
                    end
                end
                S_WAIT_OUT: begin
                    if (free[k]) begin
                        func_d[k]  = 1'b1;
                        seen_d[k]  = 1'b0;
                        state_d[k] = S_FUNC;
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase
        end
        for (int unsigned k = 0; k < NUM_LAYERS - 1; k++) begin
            if (func_done[k]) begin
                full_d[k+1] = 1'b1;
            end
        end
        if (i_frame_valid && o_frame_ready) begin
            full_d[0] = 1'b1;
        end
        result_d = func_done[NUM_LAYERS-1];
        frames_d = o_frames_done + CNT_W'(func_done[NUM_LAYERS-1]);
        idle_d   = !any_active && (full_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= '0;
            end
            seen_q         <= '0;
            full_q         <= '0;
            o_start        <= '0;
            o_func_start   <= '0;
            o_result_valid <= 1'b0;
            o_frames_done  <= '0;
            o_idle         <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            seen_q         <= seen_d;
            full_q         <= full_d;
            o_start        <= start_d;
            o_func_start   <= func_d;
            o_result_valid <= result_d;
            o_frames_done  <= frames_d;
            o_idle         <= idle_d;
        end
    end

endmodule
